// File: rtl/bus_scatter_packer.sv
// Packs BEATS accepted WIDTH-bit words into a NUM_OUT-bit frame.
// The frame is built in a shadow register and committed to o_bus in one step, so partial frames never appear.
module bus_scatter_packer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_OUT   = 200,
    parameter logic        RESET_VAL = 1'b0,
    localparam int unsigned BEATS    = (NUM_OUT + WIDTH - 1) / WIDTH,
    localparam int unsigned IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i0,
    input  logic [WIDTH-1:0]   i1,
    input  logic [WIDTH-1:0]   i2,
    input  logic [1:0]         mode,
    input  logic               clear,
    output logic               in_ready,
    output logic               o,
    output logic [NUM_OUT-1:0] o_bus,
    output logic [IDX_W-1:0]   beat_idx
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     beat_q, beat_d;
    logic [NUM_OUT-1:0]   shadow_q, shadow_d;
    logic [NUM_OUT-1:0]   o_bus_q, o_bus_d;
    logic                 o_q, o_d;
    logic                 in_ready_q, in_ready_d;
    logic [WIDTH-1:0]     word_c;

    // Per-beat combine of the two input words.
    always_comb begin
        word_c = i1;
        unique case (mode)
            2'b00: word_c = i1;
            2'b01: word_c = i1 ^ i2;
            2'b10: word_c = i1 & i2;
            2'b11: word_c = WIDTH'(i1 + i2);
            default: word_c = i1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            shadow_q   <= '0;
            o_bus_q    <= {NUM_OUT{RESET_VAL}};
            o_q        <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            shadow_q   <= shadow_d;
            o_bus_q    <= o_bus_d;
            o_q        <= o_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic; clear wins over a simultaneous beat, but never interrupts COMMIT.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        shadow_d = shadow_q;
        o_bus_d  = o_bus_q;
        o_d      = 1'b0;

        unique case (state_q)
            IDLE, FILL: begin
                if (clear) begin
                    state_d  = IDLE;
                    beat_d   = '0;
                    shadow_d = '0;
                end else if (i0 && in_ready_q) begin
                    // Bits of the last beat at or above NUM_OUT fall outside the loop and are dropped.
                    for (int unsigned j = 0; j < NUM_OUT; j++) begin
                        if (IDX_W'(j / WIDTH) == beat_q) begin
                            shadow_d[j] = word_c[j % WIDTH];
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = FILL;
                        beat_d  = beat_q + IDX_W'(1);
                    end
                end
            end
            COMMIT: begin
                o_bus_d = shadow_q;
                o_d     = 1'b1;
                beat_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        in_ready_d = (state_d != COMMIT);
    end

    assign in_ready = in_ready_q;
    assign o        = o_q;
    assign o_bus    = o_bus_q;
    assign beat_idx = beat_q;

endmodule
